fetch_unit: RTL

//  Instruction fetch stage upstream of the 16-bit CPU datapath. Holds the fetch PC,

---
 rtl/cpu_pkg.sv | 14 +
 rtl/fetch_fifo.sv | 64 ++++++
 rtl/fetch_unit.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared constants and fetch FSM encoding for the 16-bit CPU front end.
package cpu_pkg;

    localparam int          ADDR_W           = 16;
    localparam int          INST_W           = 16;
    localparam logic [15:0] PC_RESET_DEFAULT = 16'd10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding {pc, instruction} pairs; head is read combinationally.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_flush,
    input  logic [WIDTH-1:0]           i_wdata,
    output logic [WIDTH-1:0]           o_rdata,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    // Storage is reset too so the head outputs read zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_wdata;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, the req/ack memory FSM and redirect handling,
// buffering fetched instructions for decode in a fetch_fifo.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [15:0] PC_RESET = PC_RESET_DEFAULT,
    parameter int          DEPTH    = 4,
    parameter int          DATA_W   = INST_W
) (
    input  logic              Clock,
    input  logic              Resetn,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    output logic [DATA_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              inst_ready
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int FW = ADDR_W + DATA_W;

    fetch_state_t      r_state, w_state_n;
    logic [ADDR_W-1:0] r_fetch_pc, w_fetch_pc_n;
    logic              r_req, w_req_n;
    logic [ADDR_W-1:0] r_addr, w_addr_n;

    logic [ADDR_W-1:0] w_target;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_drop_pc;
    logic              w_ack_take;
    logic              w_push;
    logic              w_pop;
    logic              w_empty;
    logic              w_full;
    logic [CW-1:0]     w_count;
    logic [CW-1:0]     w_count_next;
    logic              w_space;
    logic [FW-1:0]     w_head;
    logic              w_unused;

    assign w_unused   = redirect_pc[0];
    assign w_target   = {redirect_pc[ADDR_W-1:1], 1'b0};
    assign w_pc_inc   = r_fetch_pc + 16'd2;
    assign w_drop_pc  = redirect ? w_target : r_fetch_pc;
    assign w_ack_take = imem_ack & (r_state == S_WAIT);
    assign w_push     = w_ack_take & ~redirect & (~w_full | w_pop);
    assign w_pop      = inst_valid & inst_ready & ~redirect;

    assign imem_req   = r_req;
    assign imem_addr  = r_addr;
    assign inst_valid = ~w_empty;
    assign inst_pc    = w_head[FW-1:DATA_W];
    assign inst       = w_head[DATA_W-1:0];

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FW)
    ) u_fifo (
        .clk     (Clock),
        .rst_n   (Resetn),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect),
        .i_wdata ({r_addr, imem_rdata}),
        .o_rdata (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Occupancy after this edge, so a new request never overfills the buffer.
    always_comb begin
        w_count_next = w_count;
        if (redirect) begin
            w_count_next = '0;
        end else begin
            if (w_push) w_count_next = w_count_next + CW'(1);
            if (w_pop)  w_count_next = w_count_next - CW'(1);
        end
        w_space = (w_count_next < CW'(DEPTH));
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= PC_RESET;
            r_req      <= 1'b0;
            r_addr     <= PC_RESET;
        end else begin
            r_state    <= w_state_n;
            r_fetch_pc <= w_fetch_pc_n;
            r_req      <= w_req_n;
            r_addr     <= w_addr_n;
        end
    end

    // A discarded read is followed straight away by the request to the redirect target.
    always_comb begin
        w_state_n    = r_state;
        w_fetch_pc_n = r_fetch_pc;
        w_req_n      = r_req;
        w_addr_n     = r_addr;
        case (r_state)
            S_IDLE: begin
                if (redirect) begin
                    w_fetch_pc_n = w_target;
                    w_req_n      = 1'b1;
                    w_addr_n     = w_target;
                    w_state_n    = S_WAIT;
                end else if (w_space) begin
                    w_req_n   = 1'b1;
                    w_addr_n  = r_fetch_pc;
                    w_state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    w_fetch_pc_n = w_target;
                    if (imem_ack) begin
                        w_addr_n = w_target;
                    end else begin
                        w_state_n = S_DROP;
                    end
                end else if (imem_ack) begin
                    w_fetch_pc_n = w_pc_inc;
                    if (w_space) begin
                        w_addr_n = w_pc_inc;
                    end else begin
                        w_req_n   = 1'b0;
                        w_state_n = S_IDLE;
                    end
                end
            end
            S_DROP: begin
                w_fetch_pc_n = w_drop_pc;
                if (imem_ack) begin
                    w_req_n   = 1'b1;
                    w_addr_n  = w_drop_pc;
                    w_state_n = S_WAIT;
                end
            end
            default: begin
                w_req_n   = 1'b0;
                w_state_n = S_IDLE;
            end
        endcase
    end

endmodule
